// File: rtl/layer_train_driver.sv
// Training sequencer for a learning neuron layer: accepts labelled samples, runs forward/learn passes,
// and tracks per-epoch absolute error when LAYER_TRAIN_DRIVER_ERR_EN is defined.
package layer_train_driver_pkg;
  typedef logic [7:0] zero2one_t;
endpackage

module layer_train_driver
  import layer_train_driver_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned M      = 52,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned EW     = 24
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           num_epochs,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  zero2one_t [N-1:0]     sample_in,
  input  zero2one_t [M-1:0]     sample_target,
  input  logic                  sample_last,
  output logic                  valid,
  output logic                  learn,
  output zero2one_t [N-1:0]     in,
  output zero2one_t [M-1:0]     expected_out,
  input  zero2one_t [M-1:0]     out,
  output logic                  busy,
  output logic                  done,
  output logic                  epoch_done,
  output logic [15:0]           epoch_count,
  output logic [EW-1:0]         err_last
);

  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FWD, S_LEARN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             last_q, last_d;
  logic [15:0]      num_q, num_d;
  logic [15:0]      ep_cnt_q, ep_cnt_d;
  zero2one_t [N-1:0] in_q, in_d;
  zero2one_t [M-1:0] exp_q, exp_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             learn_q, learn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ep_done_q, ep_done_d;

  // Sequencing: next state plus registered outputs derived from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q | stop;
    last_d    = last_q;
    num_d     = num_q;
    ep_cnt_d  = ep_cnt_q;
    in_d      = in_q;
    exp_d     = exp_q;
    ep_done_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        stop_d = 1'b0;
        if (start) begin
          num_d    = num_epochs;
          ep_cnt_d = 16'd0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_q) begin
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sample_valid) begin
          in_d    = sample_in;
          exp_d   = sample_target;
          last_d  = sample_last;
          cnt_d   = '0;
          state_d = S_FWD;
        end
      end
      S_FWD: begin
        if (cnt_q == CW'(SETTLE - 1)) state_d = S_LEARN;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      S_LEARN: begin
        state_d = S_WAIT;
        if (last_q) begin
          ep_done_d = 1'b1;
          ep_cnt_d  = (ep_cnt_q == 16'hFFFF) ? ep_cnt_q : ep_cnt_q + 16'd1;
          if ((num_q != 16'd0) && (ep_cnt_d == num_q)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_WAIT) && !stop_d;
    valid_d = (state_d == S_FWD) || (state_d == S_LEARN);
    learn_d = (state_d == S_LEARN);
    busy_d  = (state_d == S_WAIT) || (state_d == S_FWD) || (state_d == S_LEARN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      last_q    <= 1'b0;
      num_q     <= 16'd0;
      ep_cnt_q  <= 16'd0;
      in_q      <= '0;
      exp_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      learn_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ep_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      last_q    <= last_d;
      num_q     <= num_d;
      ep_cnt_q  <= ep_cnt_d;
      in_q      <= in_d;
      exp_q     <= exp_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      learn_q   <= learn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ep_done_q <= ep_done_d;
    end
  end

  assign sample_ready = ready_q;
  assign valid        = valid_q;
  assign learn        = learn_q;
  assign in           = in_q;
  assign expected_out = exp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign epoch_done   = ep_done_q;
  assign epoch_count  = ep_cnt_q;

`ifdef LAYER_TRAIN_DRIVER_ERR_EN
  localparam int unsigned ZW    = $bits(zero2one_t);
  localparam int unsigned SUM_W = ZW + $clog2(M + 1);
  localparam int unsigned AW    = ((EW > SUM_W) ? EW : SUM_W) + 1;
  localparam logic [AW-1:0] SAT_MAX = AW'({EW{1'b1}});

  zero2one_t [M-1:0] snap_q, snap_d;
  logic [EW-1:0]     acc_q, acc_d;
  logic [EW-1:0]     err_q, err_d;
  logic [SUM_W-1:0]  sum_c;
  logic [AW-1:0]     acc_sum_c;
  logic [EW-1:0]     acc_sat_c;

  // Sum of absolute target/snapshot differences for the sample in LEARN.
  always_comb begin
    sum_c = '0;
    for (int unsigned j = 0; j < M; j++) begin
      sum_c = sum_c + SUM_W'((exp_q[j] > snap_q[j]) ? (exp_q[j] - snap_q[j])
                                                    : (snap_q[j] - exp_q[j]));
    end
    acc_sum_c = AW'(acc_q) + AW'(sum_c);
    acc_sat_c = (acc_sum_c > SAT_MAX) ? {EW{1'b1}} : EW'(acc_sum_c);
  end

  always_comb begin
    snap_d = snap_q;
    acc_d  = acc_q;
    err_d  = err_q;
    if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) acc_d = '0;
    if ((state_q == S_FWD) && (cnt_q == CW'(SETTLE - 1)))      snap_d = out;
    if (state_q == S_LEARN) begin
      acc_d = acc_sat_c;
      if (last_q) begin
        err_d = acc_sat_c;
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= '0;
      acc_q  <= '0;
      err_q  <= '0;
    end else begin
      snap_q <= snap_d;
      acc_q  <= acc_d;
      err_q  <= err_d;
    end
  end

  assign err_last = err_q;
`else
  logic unused_out;
  assign unused_out = ^out;
  assign err_last   = '0;
`endif

endmodule

// File: tb/tb_layer_train_driver.sv
// Directed bench for layer_train_driver: single sample, backpressure/multi-epoch, stop, saturation, async reset.
module tb_layer_train_driver;
  import layer_train_driver_pkg::*;

  localparam int unsigned N = 16;
  localparam int unsigned M = 52;
`ifdef LAYER_TRAIN_DRIVER_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic start, stop, sample_valid, sample_last;
  logic [15:0] num_epochs;
  zero2one_t [N-1:0] sample_in;
  zero2one_t [M-1:0] sample_target, out;

  logic sample_ready, valid, learn, busy, done, epoch_done;
  zero2one_t [N-1:0] in;
  zero2one_t [M-1:0] expected_out;
  logic [15:0] epoch_count;
  logic [23:0] err_last;

  logic s_ready, s_valid, s_learn, s_busy, s_done, s_epoch_done;
  zero2one_t [N-1:0] s_in;
  zero2one_t [M-1:0] s_expected_out;
  logic [15:0] s_epoch_count;
  logic [7:0]  s_err_last;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  layer_train_driver #(.N(N), .M(M), .SETTLE(2), .EW(24)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .num_epochs(num_epochs),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_in(sample_in),
    .sample_target(sample_target), .sample_last(sample_last), .valid(valid), .learn(learn),
    .in(in), .expected_out(expected_out), .out(out), .busy(busy), .done(done),
    .epoch_done(epoch_done), .epoch_count(epoch_count), .err_last(err_last)
  );

  layer_train_driver #(.N(N), .M(M), .SETTLE(2), .EW(8)) u_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .num_epochs(num_epochs),
    .sample_valid(sample_valid), .sample_ready(s_ready), .sample_in(sample_in),
    .sample_target(sample_target), .sample_last(sample_last), .valid(s_valid), .learn(s_learn),
    .in(s_in), .expected_out(s_expected_out), .out(out), .busy(s_busy), .done(s_done),
    .epoch_done(s_epoch_done), .epoch_count(s_epoch_count), .err_last(s_err_last)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [N*8-1:0] pat_in(input int k);
    logic [7:0] b;
    b = 8'(k + 1);
    return {N{b}};
  endfunction

  function automatic logic [M*8-1:0] all_m(input logic [7:0] v);
    return {M{v}};
  endfunction

  initial begin
    int idx, rdy, consec, nep;
    int ep_cyc [3];
    logic adv, prev_rdy;
    logic [N*8-1:0] cur;

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; num_epochs = 16'd0;
    sample_valid = 1'b0; sample_last = 1'b0; sample_in = '0; sample_target = '0; out = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);   chk("rst_ready", sample_ready, 0);
    chk("rst_valid", valid, 0); chk("rst_learn", learn, 0);
    chk("rst_done", done, 0);   chk("rst_epoch_done", epoch_done, 0);
    chk("rst_epoch_count", epoch_count, 0); chk("rst_err", err_last, 0);
    chk("rst_in", in, 0);       chk("rst_exp", expected_out, 0);
    reset_n = 1'b1;
    tick();

    // Single sample, one epoch
    num_epochs = 16'd1; start = 1'b1; sample_valid = 1'b1; sample_last = 1'b1;
    sample_in = pat_in(4); sample_target = all_m(8'd10); out = '0;
    tick(); start = 1'b0;
    chk("ss_wait_ready", sample_ready, 1); chk("ss_wait_busy", busy, 1); chk("ss_wait_valid", valid, 0);
    tick(); sample_valid = 1'b0;
    chk("ss_fwd1_valid", valid, 1); chk("ss_fwd1_learn", learn, 0); chk("ss_fwd1_ready", sample_ready, 0);
    chk("ss_in", in, pat_in(4)); chk("ss_exp", expected_out, all_m(8'd10));
    tick();
    chk("ss_fwd2_valid", valid, 1); chk("ss_fwd2_learn", learn, 0);
    tick();
    chk("ss_learn_valid", valid, 1); chk("ss_learn", learn, 1); chk("ss_learn_epoch_done", epoch_done, 0);
    tick();
    chk("ss_epoch_done", epoch_done, 1); chk("ss_done", done, 1); chk("ss_busy", busy, 0);
    chk("ss_learn_off", learn, 0); chk("ss_valid_off", valid, 0);
    chk("ss_epoch_count", epoch_count, 1);
    chk("ss_err", err_last, (ERR_ON != 0) ? 520 : 0);
    chk("ss_sat_err", s_err_last, (ERR_ON != 0) ? 255 : 0);
    tick();
    chk("ss_epoch_done_pulse", epoch_done, 0); chk("ss_done_sticky", done, 1);
    chk("ss_in_hold", in, pat_in(4));

    // Backpressure and three epochs of four samples
    num_epochs = 16'd3; start = 1'b1; sample_valid = 1'b1; sample_last = 1'b0;
    sample_target = all_m(8'd1); out = '0; idx = 0; sample_in = pat_in(0);
    rdy = 0; consec = 0; nep = 0; adv = 1'b0; prev_rdy = 1'b0; cur = '0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      tick();
      if (cyc == 0) start = 1'b0;
      if (adv) begin
        cur = pat_in(idx);
        idx++;
        sample_in = pat_in(idx);
        sample_last = ((idx % 4) == 3);
        adv = 1'b0;
      end
      if (valid) chk("bp_in_stable", in, cur);
      if (sample_ready) begin
        rdy++;
        if (prev_rdy) consec++;
        adv = 1'b1;
      end
      prev_rdy = sample_ready;
      if (epoch_done) begin
        if (nep < 3) ep_cyc[nep] = cyc;
        nep++;
        chk("me_epoch_count", epoch_count, nep);
        chk("me_err", err_last, (ERR_ON != 0) ? 208 : 0);
        chk("me_sat_err", s_err_last, (ERR_ON != 0) ? 208 : 0);
      end
    end
    sample_valid = 1'b0;
    chk("bp_ready_cycles", rdy, 12);
    chk("bp_ready_back_to_back", consec, 0);
    chk("me_epochs", nep, 3);
    chk("me_first_epoch_cycle", ep_cyc[0], 16);
    chk("me_gap1", ep_cyc[1] - ep_cyc[0], 16);
    chk("me_gap2", ep_cyc[2] - ep_cyc[1], 16);
    chk("me_done", done, 1); chk("me_busy", busy, 0); chk("me_final_count", epoch_count, 3);

    // Stop during FWD of the second sample
    num_epochs = 16'd0; start = 1'b1; sample_valid = 1'b1; sample_last = 1'b0; sample_in = pat_in(20);
    tick(); start = 1'b0;
    chk("st_done_cleared", done, 0); chk("st_busy", busy, 1); chk("st_ready", sample_ready, 1);
    tick(); chk("st_s1_valid", valid, 1);
    tick(); tick(); chk("st_s1_learn", learn, 1);
    tick(); chk("st_s2_ready", sample_ready, 1);
    tick(); chk("st_s2_fwd", valid, 1); stop = 1'b1;
    tick(); stop = 1'b0;
    tick(); chk("st_learn_kept", learn, 1);
    tick(); chk("st_no_ready", sample_ready, 0); chk("st_learn_off", learn, 0);
    tick(); chk("st_idle_busy", busy, 0); chk("st_idle_done", done, 0);
    for (int k = 0; k < 6; k++) begin
      tick(); chk("st_stay_idle", sample_ready, 0);
    end
    chk("st_count", epoch_count, 0);

    // Saturation, with start and stop together from IDLE
    num_epochs = 16'd1; start = 1'b1; stop = 1'b1; sample_last = 1'b1;
    sample_target = all_m(8'd255); out = '0;
    tick(); start = 1'b0; stop = 1'b0;
    chk("sv_start_stop_ready", sample_ready, 1);
    tick(); tick(); tick(); chk("sv_learn", learn, 1);
    tick();
    chk("sv_done", done, 1); chk("sv_epoch_done", epoch_done, 1);
    chk("sv_err", err_last, (ERR_ON != 0) ? 13260 : 0);
    chk("sv_sat_err", s_err_last, (ERR_ON != 0) ? 255 : 0);

    // Snapshot larger than target
    start = 1'b1; sample_target = all_m(8'd0); out = all_m(8'd3);
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ab_done", done, 1);
    chk("ab_err", err_last, (ERR_ON != 0) ? 156 : 0);
    chk("ab_sat_err", s_err_last, (ERR_ON != 0) ? 156 : 0);

    // Async reset in the LEARN cycle
    num_epochs = 16'd0; start = 1'b1; sample_last = 1'b0;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("ar_learn_before", learn, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_learn_async", learn, 0); chk("ar_valid_async", valid, 0); chk("ar_busy_async", busy, 0);
    chk("ar_count_async", epoch_count, 0); chk("ar_err_async", err_last, 0);
    sample_valid = 1'b0;
    tick(); reset_n = 1'b1;
    tick();
    chk("ar_busy", busy, 0); chk("ar_ready", sample_ready, 0); chk("ar_done", done, 0);
    chk("ar_count", epoch_count, 0); chk("ar_in", in, 0); chk("ar_err", err_last, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
